mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequencer for the shared iterative multiply/divide unit that sits beside the ALU in the EXE stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues from EXE, runs the 32-step shift-add or restoring-divide datapath, and holds the pipeline stall while an operation is in flight. Owns the architectural HI/LO registers. Aborts cleanly on a branch-unit flush.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width. 32 is the only supported value.
- `STEPS`, WIDTH, number of iteration cycles per multiply/divide.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `i_MDU_start`  in  1  issue request from EXE, valid for one cycle.
- `i_MDU_op`  in  3  operation code; encodings are in `mdu_pkg`.
- `i_MDU_A`  in  32  rs operand (dividend, multiplicand, or MTHI/MTLO data).
- `i_MDU_B`  in  32  rt operand (divisor or multiplier).
- `i_MDU_clr`  in  1  flush from the branch unit; kills any in-flight operation.
- `o_MDU_stall`  out  1  freezes IF/ID/EXE while high.
- `o_MDU_busy`  out  1  FSM is outside IDLE.
- `o_MDU_done`  out  1  one-cycle pulse when HI/LO commit a multiply/divide result.
- `o_MDU_hi`  out  32  HI register.
- `o_MDU_lo`  out  32  LO register.

## Operation
- **FSM states:** IDLE, MUL, DIV, FIX, DONE.
- **Reset values:** state=IDLE; counter=0; HI=0; LO=0; stall=0; busy=0; done=0.
- **IDLE:**
  - start with MTHI or MTLO: HI or LO gets `i_MDU_A` at the next edge. No stall. State stays IDLE.
  - start with MULT/MULTU: latch operands; take absolute values for the signed case and record the result sign. Go to MUL, counter=0.
  - start with DIV/DIVU: same latching and sign capture, with quotient and remainder signs recorded separately. Go to DIV.
  - Undefined op codes are ignored.
- **MUL:** one shift-add step per cycle over a 64-bit accumulator. After STEPS cycles, go to FIX.
- **DIV:** one restoring step per cycle. Remainder is 33 bits wide, quotient shifts into the low word. After STEPS cycles, go to FIX.
- **FIX:** apply the sign corrections. Multiply: negate the 64-bit product if the result sign is set. Divide: negate the quotient and/or remainder as recorded; the remainder takes the dividend's sign. Go to DONE.
- **DONE:** HI/LO are written. Multiply: HI=product[63:32], LO=product[31:0]. Divide: HI=remainder, LO=quotient. done=1. Return to IDLE.
- **Divide by zero:** no trap. DIVU gives LO=0xFFFFFFFF, HI=dividend. DIV gives the result of the unsigned rule followed by sign fix-up. Cycle count is unchanged.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Flush:** `i_MDU_clr` in any state forces IDLE at the next edge. HI/LO are left unchanged; done does not pulse.
  - clr together with start in IDLE: clr wins, and the issue (MTHI/MTLO included) is dropped.
  - clr in DONE: the commit is suppressed.
- **Ignored starts:** start while busy is ignored. The pipeline is stalled, so EXE holds and re-presents nothing new.
- **Stall:** stall = (IDLE & start & op is MUL/DIV class & !clr) | MUL | DIV | FIX. Stall is low in DONE so the stalled instruction retires as HI/LO commit.

## Timing
- Issue cycle T0: stall is high combinationally.
- T1..T32: iteration. T33: FIX. T34: DONE, with done=1 and stall=0. HI/LO are visible from T35.
- Total latency is STEPS+3 cycles from issue to readable HI/LO.
- MTHI/MTLO: value visible one cycle after issue.
- A new issue is accepted in the cycle immediately after DONE.
- Mid-operation `rst` is identical to power-on reset at the next edge.

## Configuration
- `MDU_FAST_MUL_EN` defined: MULT/MULTU compute the 64-bit product combinationally in the issue cycle and go directly to DONE. Stall is high only in the issue cycle, and done pulses at T1. DIV path is unchanged.
- Undefined: the iterative MUL path is used as above.

## Structure
- `mdu_pkg` holds:
  - the op encodings: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5;
  - the FSM state typedef;
  - the `MDU_W` constant.
- One sub-module: `mdu_div_step`, a combinational single restoring-divide step (remainder, quotient in; remainder, quotient out).
- FSM, counter, sign logic and HI/LO stay in `mdu_ctrl`.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001, done at T34, stall high T0..T33.
- MULT -3×7: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0: LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Load HI=0x11 with MTHI, start DIVU, assert clr at T10: back to IDLE at T11, HI still 0x11, no done pulse. Then MTLO 0x22 gives LO=0x22 one cycle later.
- With `MDU_FAST_MUL_EN`, MULT 5×6: LO=30 and done at T1. Without the macro, the same stimulus gives done at T34.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// operand width and a conditional absolute-value helper.
package mdu_pkg;

  localparam int MDU_W = 32;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_e;

  // Magnitude of x when treated as signed (en=1); pass-through otherwise.
  function automatic logic [MDU_W-1:0] mdu_abs(input logic [MDU_W-1:0] x, input logic en);
    return (en && x[MDU_W-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int W = MDU_W
) (
  input  logic [W:0]   rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W:0]   rem_o,
  output logic [W-1:0] quo_o
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    diff    = shifted - {2'b00, dvsr_i};
    if (diff[W+1]) begin
      rem_o = shifted[W:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end else begin
      rem_o = diff[W:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO, with pipeline stall and flush.
// Define MDU_FAST_MUL_EN to compute MULT/MULTU in a single cycle.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_W,
  parameter int STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_MDU_start,
  input  logic [2:0]       i_MDU_op,
  input  logic [WIDTH-1:0] i_MDU_A,
  input  logic [WIDTH-1:0] i_MDU_B,
  input  logic             i_MDU_clr,
  output logic             o_MDU_stall,
  output logic             o_MDU_busy,
  output logic             o_MDU_done,
  output logic [WIDTH-1:0] o_MDU_hi,
  output logic [WIDTH-1:0] o_MDU_lo
);

  localparam int CW = $clog2(STEPS + 1);

  mdu_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic               is_div_q;
  logic               neg_prod_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_signed_d;
  logic               md_issue_d;
  logic               last_d;
  logic [WIDTH-1:0]   abs_a_d;
  logic [WIDTH-1:0]   abs_b_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_fix_d;
  logic [WIDTH:0]     rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_fix_d;
  logic [WIDTH-1:0]   quo_fix_d;

  assign is_signed_d = (i_MDU_op == MDU_MULT) || (i_MDU_op == MDU_DIV);
  assign md_issue_d  = i_MDU_start && (i_MDU_op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU});
  assign last_d      = (cnt_q == CW'(STEPS - 1));
  assign abs_a_d     = mdu_abs(i_MDU_A, is_signed_d);
  assign abs_b_d     = mdu_abs(i_MDU_B, is_signed_d);

  // Shift-add: low word holds the unconsumed multiplier bits, high word the partial sum.
  assign mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign acc_d      = {mul_sum_d, acc_q[WIDTH-1:1]};
  assign prod_fix_d = neg_prod_q ? (~acc_q + 1'b1) : acc_q;
  assign rem_fix_d  = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
  assign quo_fix_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] ext_a_d;
  logic [2*WIDTH-1:0] ext_b_d;
  logic [2*WIDTH-1:0] fast_prod_d;
  assign ext_a_d     = {{WIDTH{is_signed_d & i_MDU_A[WIDTH-1]}}, i_MDU_A};
  assign ext_b_d     = {{WIDTH{is_signed_d & i_MDU_B[WIDTH-1]}}, i_MDU_B};
  assign fast_prod_d = ext_a_d * ext_b_d;
`endif

  mdu_div_step #(.W(WIDTH)) u_div_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (opnd_q),
    .rem_o  (rem_d),
    .quo_o  (quo_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      is_div_q   <= 1'b0;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else if (i_MDU_clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_MDU_start) begin
            case (i_MDU_op)
              MDU_MTHI: hi_q <= i_MDU_A;
              MDU_MTLO: lo_q <= i_MDU_A;
              MDU_MULT, MDU_MULTU: begin
                opnd_q     <= abs_a_d;
                neg_prod_q <= is_signed_d & (i_MDU_A[WIDTH-1] ^ i_MDU_B[WIDTH-1]);
                is_div_q   <= 1'b0;
                cnt_q      <= '0;
`ifdef MDU_FAST_MUL_EN
                acc_q      <= fast_prod_d;
                state_q    <= S_DONE;
`else
                acc_q      <= {{WIDTH{1'b0}}, abs_b_d};
                state_q    <= S_MUL;
`endif
              end
              MDU_DIV, MDU_DIVU: begin
                opnd_q    <= abs_b_d;
                quo_q     <= abs_a_d;
                rem_q     <= '0;
                neg_quo_q <= is_signed_d & (i_MDU_A[WIDTH-1] ^ i_MDU_B[WIDTH-1]);
                neg_rem_q <= is_signed_d & i_MDU_A[WIDTH-1];
                is_div_q  <= 1'b1;
                cnt_q     <= '0;
                state_q   <= S_DIV;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          cnt_q <= last_d ? '0 : cnt_q + CW'(1);
          if (last_d) state_q <= S_FIX;
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= last_d ? '0 : cnt_q + CW'(1);
          if (last_d) state_q <= S_FIX;
        end
        S_FIX: begin
          // Both results are staged in acc_q so DONE commits them uniformly.
          acc_q   <= is_div_q ? {rem_fix_d, quo_fix_d} : prod_fix_d;
          state_q <= S_DONE;
        end
        S_DONE: begin
          hi_q    <= acc_q[2*WIDTH-1:WIDTH];
          lo_q    <= acc_q[WIDTH-1:0];
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_MDU_stall = ((state_q == S_IDLE) && md_issue_d && !i_MDU_clr) ||
                       (state_q inside {S_MUL, S_DIV, S_FIX});
  assign o_MDU_busy  = (state_q != S_IDLE);
  assign o_MDU_done  = (state_q == S_DONE) && !i_MDU_clr;
  assign o_MDU_hi    = hi_q;
  assign o_MDU_lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases, flush, reset and
// randomized operations checked against an arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W = 32;

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         clr;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0;
  logic [W-1:0]   m_lo = '0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_MDU_start (start),
    .i_MDU_op    (op),
    .i_MDU_A     (a),
    .i_MDU_B     (b),
    .i_MDU_clr   (clr),
    .o_MDU_stall (stall),
    .o_MDU_busy  (busy),
    .o_MDU_done  (done),
    .o_MDU_hi    (hi),
    .o_MDU_lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from plain signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint   sx;
    longint   sy;
    logic [W-1:0] q;
    logic [W-1:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = '0;
    r  = '0;
    case (o)
      MDU_MULT:  return 64'(sx * sy);
      MDU_MULTU: return {32'b0, x} * {32'b0, y};
      MDU_DIV: begin
        if (y == 0) begin
          q = x[W-1] ? 32'h1 : 32'hFFFF_FFFF;
          r = x;
        end else begin
          q = 32'(sx / sy);
          r = 32'(sx % sy);
        end
      end
      MDU_DIVU: begin
        if (y == 0) begin
          q = 32'hFFFF_FFFF;
          r = x;
        end else begin
          q = x / y;
          r = x % y;
        end
      end
      default: ;
    endcase
    return {r, q};
  endfunction

  // Issues a multiply/divide at the current negedge and follows it to commit.
  task automatic run_md(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] e;
    int  t;
    int  exp_lat;
    bit  seen;
    bit  stall_ok;
    logic busy1;
    e = model(o, x, y);
    exp_q.push_back(e);
    exp_lat = (FAST_MUL && (o == MDU_MULT || o == MDU_MULTU)) ? 1 : 34;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check("stall_t0", 64'(stall), 64'(1));
    seen = 1'b0; stall_ok = 1'b1; t = 0; busy1 = 1'b0;
    while (!seen && t < 100) begin
      @(negedge clk);
      start = 1'b0;
      t++;
      if (t == 1) busy1 = busy;
      if (done === 1'b1) seen = 1'b1;
      else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    check("busy_t1", 64'(busy1), 64'(1));
    check("done_seen", 64'(seen), 64'(1));
    check("done_cycle", 64'(t), 64'(exp_lat));
    check("stall_until_done", 64'(stall_ok), 64'(1));
    check("stall_at_done", 64'(stall), 64'(0));
    @(negedge clk);
    check("hilo", {hi, lo}, exp_q.pop_front());
    check("done_pulse_end", 64'(done), 64'(0));
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic run_mt(input logic [2:0] o, input logic [W-1:0] x);
    start = 1'b1; op = o; a = x; b = $urandom;
    #1;
    check("mt_stall", 64'(stall), 64'(0));
    @(negedge clk);
    start = 1'b0;
    if (o == MDU_MTHI) m_hi = x; else m_lo = x;
    check("mt_hilo", {hi, lo}, {m_hi, m_lo});
    check("mt_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; clr = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_md(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_md(MDU_MULT,  32'hFFFF_FFFD, 32'd7);
    run_md(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
    run_md(MDU_DIVU,  32'd7,         32'd0);
    run_md(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_md(MDU_DIV,   32'hFFFF_FFF9, 32'd0);
    run_md(MDU_MULT,  32'd5,         32'd6);

    // Flush a divide mid-flight.
    run_mt(MDU_MTHI, 32'h11);
    start = 1'b1; op = MDU_DIVU; a = 32'd100; b = 32'd3;
    seen_done = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) seen_done = 1'b1;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_stall", 64'(stall), 64'(0));
    for (int t = 0; t < 30; t++) begin
      if (done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    check("flush_no_done", 64'(seen_done), 64'(0));
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    run_mt(MDU_MTLO, 32'h22);

    // clr together with start in IDLE drops the issue.
    start = 1'b1; op = MDU_MTHI; a = 32'h55; clr = 1'b1;
    #1;
    check("clr_start_stall", 64'(stall), 64'(0));
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    check("clr_start_hilo", {hi, lo}, {m_hi, m_lo});
    start = 1'b1; op = MDU_DIVU; a = 32'd9; b = 32'd2; clr = 1'b1;
    #1;
    check("clr_div_stall", 64'(stall), 64'(0));
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    check("clr_div_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 16; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if (ro >= MDU_MTHI) run_mt(ro, ra);
      else run_md(ro, ra, rb);
    end

    // Reset in the middle of a multiply.
    start = 1'b1; op = MDU_MULT; a = 32'd1234; b = 32'd77;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_hilo", {hi, lo}, 64'(0));
    run_md(MDU_MULTU, 32'd1234, 32'd77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
